// File: rtl/chip8_vga_scanout.sv
// chip8_vga_scanout
// Read side of the 64x32 CHIP-8 framebuffer. Produces VGA timing from a divided
// pixel tick, scales each framebuffer pixel to a SCALE x SCALE block, centres the
// image vertically and shows a shadow copy of the framebuffer taken at vblank so
// the draw unit never tears the visible frame. frame_start doubles as the 60 Hz
// timer tick for the CPU.
//
// There is no handshake with the draw unit: display_in only has to be stable on
// the latch edge. No ready/valid interface exists on this block.
//
// The raster geometry parameters default to standard 640x480@60 timing; they are
// exposed so a reduced raster can be used where a full frame is impractical.

module chip8_vga_scanout #(
   parameter int CLK_DIV      = 4,
   parameter int SCALE        = 10,
   parameter int V_OFFSET     = 80,
   parameter int H_VISIBLE    = 640,
   parameter int H_SYNC_START = 656,
   parameter int H_SYNC_END   = 751,
   parameter int H_TOTAL      = 800,
   parameter int V_VISIBLE    = 480,
   parameter int V_SYNC_START = 490,
   parameter int V_SYNC_END   = 491,
   parameter int V_TOTAL      = 525
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [2047:0] display_in,
   input  logic [11:0]   fg_color,
   input  logic [11:0]   bg_color,
   output logic          hsync,
   output logic          vsync,
   output logic [11:0]   vga_rgb,
   output logic          frame_start
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START   = 10'(H_SYNC_START);
   localparam logic [9:0] HS_END     = 10'(H_SYNC_END);
   localparam logic [9:0] VS_START   = 10'(V_SYNC_START);
   localparam logic [9:0] VS_END     = 10'(V_SYNC_END);
   localparam logic [9:0] H_IMG_END  = 10'(64 * SCALE);
   localparam logic [9:0] V_IMG_BEG  = 10'(V_OFFSET);
   localparam logic [9:0] V_IMG_END  = 10'(V_OFFSET + 32 * SCALE);
   localparam logic [3:0] SUB_LAST   = 4'(SCALE - 1);

   logic [DIV_W-1:0] div;
   logic             pix_tick;
   logic [9:0]       h;
   logic [9:0]       v;
   // Horizontal block position: h = px*SCALE + sx inside the image.
   logic [5:0]       px;
   logic [3:0]       sx;
   // Vertical block position: v - V_OFFSET = py*SCALE + sy inside the image.
   logic [4:0]       py;
   logic [3:0]       sy;
   logic [2047:0]    shadow;
   logic             h_wrap;
   logic             v_wrap;
   logic             img;
   logic             latch;

   assign pix_tick = (div == DIV_LAST);
   assign h_wrap   = (h == H_LAST);
   assign v_wrap   = (v == V_LAST);
   assign latch    = pix_tick && (h == 10'd0) && (v == V_VIS);

   // Image-area decode for the current (pre-advance) raster position.
   always_comb begin
      img = 1'b0;
      if ((h < H_VIS) && (v < V_VIS) && (h < H_IMG_END) &&
          (v >= V_IMG_BEG) && (v < V_IMG_END)) begin
         img = 1'b1;
      end
   end

   // Pixel-tick divider: counts 0..CLK_DIV-1 and wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div <= '0;
      end else if (pix_tick) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   // Raster counters and the scale sub-counters that replace h/SCALE and v/SCALE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h  <= '0;
         v  <= '0;
         px <= '0;
         sx <= '0;
         py <= '0;
         sy <= '0;
      end else if (pix_tick) begin
         if (h_wrap) begin
            h  <= '0;
            px <= '0;
            sx <= '0;
            if (v_wrap) begin
               v  <= '0;
               py <= '0;
               sy <= '0;
            end else begin
               v <= v + 10'd1;
               // Lines above the image leave py/sy parked at zero.
               if (v >= V_IMG_BEG) begin
                  if (sy == SUB_LAST) begin
                     sy <= '0;
                     py <= py + 5'd1;
                  end else begin
                     sy <= sy + 4'd1;
                  end
               end
            end
         end else begin
            h <= h + 10'd1;
            if (sx == SUB_LAST) begin
               sx <= '0;
               px <= px + 6'd1;
            end else begin
               sx <= sx + 4'd1;
            end
         end
      end
   end

   // Output register: sync and colour for the pre-advance position, one pixel late.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hsync   <= 1'b1;
         vsync   <= 1'b1;
         vga_rgb <= 12'h000;
      end else if (pix_tick) begin
         hsync   <= !((h >= HS_START) && (h <= HS_END));
         vsync   <= !((v >= VS_START) && (v <= VS_END));
         if (img) begin
            vga_rgb <= shadow[{py, px}] ? fg_color : bg_color;
         end else begin
            vga_rgb <= 12'h000;
         end
      end
   end

   // Shadow copy taken at the start of vblank, with a one-clk frame_start pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow      <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= latch;
         if (latch) begin
            shadow <= display_in;
         end
      end
   end

endmodule

// File: tb/tb_chip8_vga_scanout.sv
// Bench for chip8_vga_scanout. Two instances on reduced rasters run side by side:
// A uses a divided tick with SCALE=1, B ticks every clk with SCALE=2. A reference
// model derives each tick's raster position from the number of clks since reset
// release and evaluates the sync/colour rules directly.

module tb_chip8_vga_scanout;

   // Instance A geometry
   localparam int A_DIV = 3, A_SC = 1, A_VOFF = 1;
   localparam int A_HV = 66, A_HS0 = 68, A_HS1 = 69, A_HT = 72;
   localparam int A_VV = 34, A_VS0 = 35, A_VS1 = 35, A_VT = 37;
   // Instance B geometry
   localparam int B_DIV = 1, B_SC = 2, B_VOFF = 2;
   localparam int B_HV = 132, B_HS0 = 134, B_HS1 = 137, B_HT = 140;
   localparam int B_VV = 68, B_VS0 = 69, B_VS1 = 70, B_VT = 72;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [2047:0] display_in;
   logic [11:0]   fg_color;
   logic [11:0]   bg_color;
   logic          a_hsync, a_vsync, a_fs;
   logic [11:0]   a_rgb;
   logic          b_hsync, b_vsync, b_fs;
   logic [11:0]   b_rgb;

   int assertions = 0;
   int failures   = 0;
   int cyc        = 0;
   int disp_tag   = 0;
   int phase      = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   chip8_vga_scanout #(
      .CLK_DIV(A_DIV), .SCALE(A_SC), .V_OFFSET(A_VOFF),
      .H_VISIBLE(A_HV), .H_SYNC_START(A_HS0), .H_SYNC_END(A_HS1), .H_TOTAL(A_HT),
      .V_VISIBLE(A_VV), .V_SYNC_START(A_VS0), .V_SYNC_END(A_VS1), .V_TOTAL(A_VT)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .display_in(display_in),
      .fg_color(fg_color), .bg_color(bg_color),
      .hsync(a_hsync), .vsync(a_vsync), .vga_rgb(a_rgb), .frame_start(a_fs)
   );

   chip8_vga_scanout #(
      .CLK_DIV(B_DIV), .SCALE(B_SC), .V_OFFSET(B_VOFF),
      .H_VISIBLE(B_HV), .H_SYNC_START(B_HS0), .H_SYNC_END(B_HS1), .H_TOTAL(B_HT),
      .V_VISIBLE(B_VV), .V_SYNC_START(B_VS0), .V_SYNC_END(B_VS1), .V_TOTAL(B_VT)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .display_in(display_in),
      .fg_color(fg_color), .bg_color(bg_color),
      .hsync(b_hsync), .vsync(b_vsync), .vga_rgb(b_rgb), .frame_start(b_fs)
   );

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // What the display shows for raster position (h,v), straight from the rules.
   function automatic logic [13:0] ref_pixel(input int h, input int v, input int sc,
         input int voff, input int hvis, input int vvis, input int hs0, input int hs1,
         input int vs0, input int vs1, input logic [2047:0] sh,
         input logic [11:0] fg, input logic [11:0] bg);
      logic hs, vs;
      logic [11:0] rgb;
      hs  = !(h >= hs0 && h <= hs1);
      vs  = !(v >= vs0 && v <= vs1);
      rgb = 12'h000;
      if (h < hvis && v < vvis && h < 64 * sc && v >= voff && v < voff + 32 * sc)
         rgb = sh[((v - voff) / sc) * 64 + h / sc] ? fg : bg;
      return {hs, vs, rgb};
   endfunction

   // ---------------- reference model ----------------
   int            am_edges = 0, bm_edges = 0;
   logic [2047:0] am_shadow = '0, bm_shadow = '0;
   logic          am_hs = 1'b1, am_vs = 1'b1, am_fs = 1'b0;
   logic          bm_hs = 1'b1, bm_vs = 1'b1, bm_fs = 1'b0;
   logic [11:0]   am_rgb = 12'h000, bm_rgb = 12'h000;
   int            am_h = 0, am_v = 0, am_tag = 0, bm_h = 0, bm_v = 0, bm_tag = 0;
   bit            am_valid = 1'b0, bm_valid = 1'b0;

   // Model for A: tick k happens on clk edge k*A_DIV + A_DIV-1 after release.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         am_edges = 0; am_shadow = '0; am_hs = 1'b1; am_vs = 1'b1;
         am_rgb = 12'h000; am_fs = 1'b0; am_tag = 0; am_valid = 1'b0;
      end else begin
         am_fs = 1'b0;
         if (am_edges % A_DIV == A_DIV - 1) begin
            int p;
            p    = (am_edges / A_DIV) % (A_HT * A_VT);
            am_h = p % A_HT;
            am_v = p / A_HT;
            {am_hs, am_vs, am_rgb} = ref_pixel(am_h, am_v, A_SC, A_VOFF, A_HV, A_VV,
               A_HS0, A_HS1, A_VS0, A_VS1, am_shadow, fg_color, bg_color);
            if (am_h == 0 && am_v == A_VV) begin
               am_shadow = display_in; am_fs = 1'b1; am_tag = disp_tag;
            end
            am_valid = 1'b1;
         end
         am_edges++;
      end
   end

   // Model for B.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bm_edges = 0; bm_shadow = '0; bm_hs = 1'b1; bm_vs = 1'b1;
         bm_rgb = 12'h000; bm_fs = 1'b0; bm_tag = 0; bm_valid = 1'b0;
      end else begin
         bm_fs = 1'b0;
         if (bm_edges % B_DIV == B_DIV - 1) begin
            int p;
            p    = (bm_edges / B_DIV) % (B_HT * B_VT);
            bm_h = p % B_HT;
            bm_v = p / B_HT;
            {bm_hs, bm_vs, bm_rgb} = ref_pixel(bm_h, bm_v, B_SC, B_VOFF, B_HV, B_VV,
               B_HS0, B_HS1, B_VS0, B_VS1, bm_shadow, fg_color, bg_color);
            if (bm_h == 0 && bm_v == B_VV) begin
               bm_shadow = display_in; bm_fs = 1'b1; bm_tag = disp_tag;
            end
            bm_valid = 1'b1;
         end
         bm_edges++;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      check("a_hsync", 32'(a_hsync), 32'(am_hs));
      check("a_vsync", 32'(a_vsync), 32'(am_vs));
      check("a_rgb", 32'(a_rgb), 32'(am_rgb));
      check("a_frame_start", 32'(a_fs), 32'(am_fs));
      check("b_hsync", 32'(b_hsync), 32'(bm_hs));
      check("b_vsync", 32'(b_vsync), 32'(bm_vs));
      check("b_rgb", 32'(b_rgb), 32'(bm_rgb));
      check("b_frame_start", 32'(b_fs), 32'(bm_fs));
      // Hand-computed pixels that pin the model.
      if (am_valid && am_tag == 1) begin
         if (am_h == 0 && am_v == 1) check("a_lit_bit0_fg", 32'(a_rgb), 32'h0FFF);
         if (am_h == 1 && am_v == 1) check("a_lit_bit0_bg", 32'(a_rgb), 32'h000F);
         if (am_h == 0 && am_v == 0) check("a_lit_top_border", 32'(a_rgb), 32'h0000);
      end
      if (bm_valid && bm_tag == 1) begin
         if (bm_h == 1 && bm_v == 3)  check("b_lit_bit0_fg", 32'(b_rgb), 32'h0FFF);
         if (bm_h == 2 && bm_v == 3)  check("b_lit_bit0_right", 32'(b_rgb), 32'h000F);
         if (bm_h == 1 && bm_v == 4)  check("b_lit_bit0_below", 32'(b_rgb), 32'h000F);
         if (bm_h == 0 && bm_v == 1)  check("b_lit_top_border", 32'(b_rgb), 32'h0000);
         if (bm_h == 0 && bm_v == 66) check("b_lit_bottom_border", 32'(b_rgb), 32'h0000);
      end
      if (bm_valid && bm_tag == 3) begin
         if (bm_h == 126 && bm_v == 64) check("b_lit_2047_tl", 32'(b_rgb), 32'h0FFF);
         if (bm_h == 127 && bm_v == 65) check("b_lit_2047_br", 32'(b_rgb), 32'h0FFF);
         if (bm_h == 125 && bm_v == 65) check("b_lit_2047_left", 32'(b_rgb), 32'h000F);
         if (bm_h == 126 && bm_v == 66) check("b_lit_2047_below", 32'(b_rgb), 32'h0000);
         if (bm_h == 128 && bm_v == 64) check("b_lit_right_border", 32'(b_rgb), 32'h0000);
         if (bm_h == 50 && bm_v == 40)  check("b_lit_no_tear", 32'(b_rgb), 32'h000F);
      end
      if (bm_valid && bm_tag == 2) begin
         if (bm_h == 50 && bm_v == 30)  check("b_lit_ones_mid", 32'(b_rgb), 32'h0FFF);
         if (bm_h == 127 && bm_v == 65) check("b_lit_ones_corner", 32'(b_rgb), 32'h0FFF);
         if (bm_h == 131 && bm_v == 30) check("b_lit_ones_border", 32'(b_rgb), 32'h0000);
      end
      if (bm_valid && bm_tag == 0 && phase == 4) begin
         if (bm_h == 1 && bm_v == 3)   check("b_lit_post_reset_bg", 32'(b_rgb), 32'h000F);
         if (bm_h == 50 && bm_v == 30) check("b_lit_post_reset_mid", 32'(b_rgb), 32'h000F);
      end
   end

   // ---------------- sync period / pulse-width measurement ----------------
   // Index 0:A hsync, 1:A vsync, 2:B hsync, 3:B vsync (periods in clk).
   int   per_exp[4] = '{216, 7992, 140, 10080};
   int   low_exp[4] = '{6, 216, 4, 280};
   int   fall_t[4];
   bit   have_fall[4] = '{0, 0, 0, 0};
   logic prev_s[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
   int   n_periods = 0;

   always @(negedge clk) begin
      logic s[4];
      s[0] = a_hsync; s[1] = a_vsync; s[2] = b_hsync; s[3] = b_vsync;
      for (int i = 0; i < 4; i++) begin
         if (!reset_n) begin
            have_fall[i] = 1'b0;
         end else if (prev_s[i] && !s[i]) begin
            if (have_fall[i]) begin
               check($sformatf("sync%0d_period", i), 32'(cyc - fall_t[i]), 32'(per_exp[i]));
               n_periods++;
            end
            fall_t[i]    = cyc;
            have_fall[i] = 1'b1;
         end else if (!prev_s[i] && s[i] && have_fall[i]) begin
            check($sformatf("sync%0d_low_width", i), 32'(cyc - fall_t[i]), 32'(low_exp[i]));
         end
         prev_s[i] = s[i];
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_cyc(input int t);
      while (cyc < t) @(posedge clk);
      #2;
   endtask

   task automatic randomize_display();
      for (int w = 0; w < 64; w++) display_in[w*32 +: 32] = $urandom;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n    = 1'b0;
      display_in = '0;
      fg_color   = 12'hFFF;
      bg_color   = 12'h00F;
      repeat (3) @(posedge clk);
      #2;
      check("reset_a_hsync", 32'(a_hsync), 32'h1);
      check("reset_a_vsync", 32'(a_vsync), 32'h1);
      check("reset_b_rgb", 32'(b_rgb), 32'h0);
      check("reset_b_fs", 32'(b_fs), 32'h0);
      display_in[0] = 1'b1;
      disp_tag      = 1;
      phase         = 1;
      reset_n       = 1'b1;

      // Only the last framebuffer bit lit.
      wait_cyc(20000);
      display_in       = '0;
      display_in[2047] = 1'b1;
      disp_tag         = 3;
      phase            = 2;

      // All ones, switched in mid-frame while a tag-3 frame is on screen.
      wait_cyc(45000);
      display_in = '1;
      disp_tag   = 2;
      phase      = 3;

      // Mid-frame reset held for 3 clk.
      wait_cyc(56000);
      reset_n = 1'b0;
      phase   = 4;
      #1;
      check("midreset_b_hsync", 32'(b_hsync), 32'h1);
      check("midreset_b_vsync", 32'(b_vsync), 32'h1);
      check("midreset_b_rgb", 32'(b_rgb), 32'h0);
      check("midreset_a_rgb", 32'(a_rgb), 32'h0);
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b1;

      // Random framebuffer and colour changes at random times.
      wait_cyc(58000);
      phase    = 5;
      disp_tag = 5;
      while (cyc < 72000) begin
         randomize_display();
         fg_color = 12'($urandom_range(0, 4095));
         bg_color = 12'($urandom_range(0, 4095));
         repeat ($urandom_range(50, 2500)) @(posedge clk);
         #2;
      end

      repeat (10) @(posedge clk);
      check("sync_periods_observed", 32'(n_periods > 20), 32'h1);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
